// File: rtl/return_addr_stack_if.sv
// Call/return port bundle for the return-address stack: the pipeline drives
// operations and reads back top-of-stack and status.
interface return_addr_stack_if #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
);
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;
    logic              stall;
    logic              checkpoint;
    logic              flush;
    logic              clr_err;
    logic [ADDR_W-1:0] top_addr;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, push_addr, stall, checkpoint, flush, clr_err,
        input  top_addr, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, push_addr, stall, checkpoint, flush, clr_err,
        output top_addr, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/return_addr_stack.sv
// Circular return-address stack with wrap-on-overflow, sticky error flags and
// a {tos, count} shadow so a pipeline flush can undo speculative calls/returns.
module return_addr_stack #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    return_addr_stack_if.slave    bus
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  tos_q, tos_d, shd_tos_q, shd_tos_d, wr_idx_s;
    logic [CNT_W-1:0]  cnt_q, cnt_d, shd_cnt_q, shd_cnt_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              wr_en_s, ovf_ev_s, unf_ev_s, empty_s, full_s;

    assign empty_s       = (cnt_q == CNT_W'(0));
    assign full_s        = (cnt_q == CNT_FULL);
    assign bus.count     = cnt_q;
    assign bus.empty     = empty_s;
    assign bus.full      = full_s;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.top_addr  = empty_s ? ADDR_W'(0) : mem_q[tos_q];

    // Next-state: flush beats stall, stall beats push/pop/checkpoint.
    always_comb begin
        tos_d     = tos_q;
        cnt_d     = cnt_q;
        shd_tos_d = shd_tos_q;
        shd_cnt_d = shd_cnt_q;
        wr_en_s   = 1'b0;
        wr_idx_s  = tos_q;
        ovf_ev_s  = 1'b0;
        unf_ev_s  = 1'b0;
        if (bus.flush) begin
            tos_d = shd_tos_q;
            cnt_d = shd_cnt_q;
        end else if (bus.stall) begin
            tos_d = tos_q;
        end else begin
            case ({bus.push, bus.pop})
                2'b10: begin
                    tos_d    = tos_q + PTR_W'(1);
                    wr_en_s  = 1'b1;
                    wr_idx_s = tos_q + PTR_W'(1);
                    if (full_s) begin
                        ovf_ev_s = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (empty_s) begin
                        unf_ev_s = 1'b1;
                    end else begin
                        tos_d = tos_q - PTR_W'(1);
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                2'b11: begin
                    wr_en_s = 1'b1;
                    // Call+return on an empty stack degenerates to a plain call.
                    if (empty_s) begin
                        tos_d    = tos_q + PTR_W'(1);
                        wr_idx_s = tos_q + PTR_W'(1);
                        cnt_d    = CNT_W'(1);
                    end else begin
                        wr_idx_s = tos_q;
                    end
                end
                default: begin
                    wr_en_s = 1'b0;
                end
            endcase
            if (bus.checkpoint) begin
                shd_tos_d = tos_d;
                shd_cnt_d = cnt_d;
            end else begin
                shd_tos_d = shd_tos_q;
            end
        end
        ovf_d = ovf_ev_s | (ovf_q & ~bus.clr_err);
        unf_d = unf_ev_s | (unf_q & ~bus.clr_err);
    end

    // Pointer, count, shadow and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tos_q     <= PTR_W'(0);
            cnt_q     <= CNT_W'(0);
            shd_tos_q <= PTR_W'(0);
            shd_cnt_q <= CNT_W'(0);
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            tos_q     <= tos_d;
            cnt_q     <= cnt_d;
            shd_tos_q <= shd_tos_d;
            shd_cnt_q <= shd_cnt_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // Entry storage; popped entries keep stale contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ADDR_W'(0);
            end
        end else if (wr_en_s) begin
            mem_q[wr_idx_s] <= bus.push_addr;
        end else begin
            mem_q[wr_idx_s] <= mem_q[wr_idx_s];
        end
    end
endmodule

// File: tb/tb_return_addr_stack.sv
// Scoreboard bench for return_addr_stack (DEPTH=4) using a list-based stack model.
module tb_return_addr_stack;
    localparam int AW = 12;
    localparam int DP = 4;
    localparam int CW = 3;

    typedef struct {
        logic [AW-1:0] top;
        logic [CW-1:0] cnt;
        logic          emp;
        logic          ful;
        logic          ovf;
        logic          unf;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb_q[$];
    int unsigned stk[$];
    int unsigned shd[$];
    logic m_ovf, m_unf;

    return_addr_stack_if #(.ADDR_W(AW), .DEPTH(DP), .CNT_W(CW)) bus ();

    return_addr_stack #(.ADDR_W(AW), .DEPTH(DP), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.cnt = CW'(stk.size());
        e.top = (stk.size() == 0) ? AW'(0) : AW'(stk[stk.size()-1]);
        e.emp = (stk.size() == 0);
        e.ful = (stk.size() == DP);
        e.ovf = m_ovf;
        e.unf = m_unf;
        return e;
    endfunction

    task automatic compare(input string tag, input exp_t e);
        check_val({tag, ".top"}, 32'(bus.top_addr), 32'(e.top));
        check_val({tag, ".cnt"}, 32'(bus.count), 32'(e.cnt));
        check_val({tag, ".emp"}, 32'(bus.empty), 32'(e.emp));
        check_val({tag, ".ful"}, 32'(bus.full), 32'(e.ful));
        check_val({tag, ".ovf"}, 32'(bus.overflow), 32'(e.ovf));
        check_val({tag, ".unf"}, 32'(bus.underflow), 32'(e.unf));
    endtask

    task automatic model_reset();
        stk.delete();
        shd.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Called just after a negedge: drive, update model, clock once, compare.
    task automatic step(input string tag, input logic p, input logic po, input logic [AW-1:0] a,
                        input logic st, input logic ck, input logic fl, input logic cl);
        logic oe, ue;
        exp_t e;
        oe = 1'b0;
        ue = 1'b0;
        bus.push = p; bus.pop = po; bus.push_addr = a;
        bus.stall = st; bus.checkpoint = ck; bus.flush = fl; bus.clr_err = cl;
        if (fl) begin
            stk = shd;
        end else if (!st) begin
            if (p && po) begin
                if (stk.size() > 0) stk[stk.size()-1] = a;
                else stk.push_back(a);
            end else if (p) begin
                if (stk.size() == DP) begin
                    void'(stk.pop_front());
                    oe = 1'b1;
                end
                stk.push_back(a);
            end else if (po) begin
                if (stk.size() > 0) void'(stk.pop_back());
                else ue = 1'b1;
            end
            if (ck) shd = stk;
        end
        m_ovf = oe | (m_ovf & ~cl);
        m_unf = ue | (m_unf & ~cl);
        sb_q.push_back(model_exp());
        @(posedge clk);
        @(negedge clk);
        bus.push = 1'b0; bus.pop = 1'b0; bus.stall = 1'b0;
        bus.checkpoint = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
        e = sb_q.pop_front();
        compare(tag, e);
    endtask

    task automatic do_push(input string tag, input logic [AW-1:0] a);
        step(tag, 1'b1, 1'b0, a, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_pop(input string tag);
        step(tag, 1'b0, 1'b1, AW'(0), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        bus.push = 1'b0; bus.pop = 1'b0; bus.push_addr = '0; bus.stall = 1'b0;
        bus.checkpoint = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
        rst = 1'b0;
        #12;
        compare("rst", model_exp());
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Fill, overflow-wrap, drain.
        do_push("p100", 12'h100);
        do_push("p200", 12'h200);
        do_push("p300", 12'h300);
        do_push("p400", 12'h400);
        do_push("p500", 12'h500);
        for (int i = 0; i < 4; i++) do_pop("drain");

        // Underflow and sticky clear.
        do_pop("uflow");
        step("uf_clr", 1'b0, 1'b1, AW'(0), 1'b0, 1'b0, 1'b0, 1'b1);
        step("clr", 1'b0, 1'b0, AW'(0), 1'b0, 1'b0, 1'b0, 1'b1);

        // Simultaneous push+pop.
        do_push("p10", 12'h010);
        do_push("p20", 12'h020);
        step("pp77", 1'b1, 1'b1, 12'h077, 1'b0, 1'b0, 1'b0, 1'b0);
        do_pop("pp_a");
        do_pop("pp_b");
        step("pp55", 1'b1, 1'b1, 12'h055, 1'b0, 1'b0, 1'b0, 1'b0);
        do_pop("pp_c");

        // Checkpoint / flush, then with stall masking the push.
        do_push("c10", 12'h010);
        do_push("c20", 12'h020);
        step("ckpt", 1'b0, 1'b0, AW'(0), 1'b0, 1'b1, 1'b0, 1'b0);
        do_push("cA0", 12'h0A0);
        do_pop("cpop1");
        do_pop("cpop2");
        step("flush", 1'b0, 1'b0, AW'(0), 1'b0, 1'b0, 1'b1, 1'b0);
        step("ckpt2", 1'b0, 1'b0, AW'(0), 1'b0, 1'b1, 1'b0, 1'b0);
        step("stallp", 1'b1, 1'b0, 12'h0A0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_pop("spop1");
        do_pop("spop2");
        step("flush2", 1'b1, 1'b1, 12'h0EE, 1'b1, 1'b1, 1'b1, 1'b0);

        // Mixed random push/pop/clear traffic.
        for (int i = 0; i < 40; i++) begin
            step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 4095)), 1'b0, 1'b0, 1'b0,
                 ($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset between edges, then resume.
        do_push("pre_r", 12'h123);
        do_push("pre_r2", 12'h456);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        compare("arst", model_exp());
        #1;
        rst = 1'b1;
        @(negedge clk);
        compare("arst_hold", model_exp());
        do_push("post", 12'h321);
        do_pop("post_pop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
